// File: rtl/yacht_pkg.sv
// Shared constants, roll FSM state encoding and the LFSR-to-face map for the Yacht dice path.
// Score calculator and display reuse the die count, die width and face range from here.
// The face map is pure combinational arithmetic on the low LFSR byte.
package yacht_pkg;

  localparam int unsigned NUM_DICE = 5;
  localparam int unsigned DIE_W    = 3;
  localparam int unsigned CURSOR_W = 3;
  localparam int unsigned FACE_MIN = 1;
  localparam int unsigned FACE_MAX = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHUFFLE = 2'd1,
    ST_UPDATE  = 2'd2,
    ST_DONE    = 2'd3
  } roll_state_t;

  // Scale a random byte onto 1..6: (r*6)>>8 lies in 0..5, so the result never leaves the face range.
  function automatic logic [DIE_W-1:0] face_map(input logic [7:0] r);
    logic [10:0] prod;
    prod = {3'b000, r} * 11'd6;
    return prod[10:8] + 3'd1;
  endfunction

endpackage

// File: rtl/dice_lfsr16.sv
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11, shifting right.
// Latency: new value every clock; reset loads the seed (seed must be nonzero).
// No backpressure: it advances unconditionally in every state.
module dice_lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Shift right; when a one falls out of bit 0, fold it back in through the tap mask.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // State register, synchronous reset to the seed.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/dice_roll_sequencer.sv
// Per-turn dice sequencer: animates un-held dice on roll_req, settles them, pulses roll_done.
// Latency: ANIM_TICKS*(TICK_DIV+NUM_DICE)+1 busy cycles per roll (1 cycle when every die is held).
// No backpressure: roll_req while busy is dropped; cursor moves in any state; all outputs registered.
module dice_roll_sequencer
  import yacht_pkg::*;
#(
  parameter int unsigned ANIM_TICKS = 8,
  parameter int unsigned TICK_DIV   = 2_500_000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      roll_req,
  input  logic                      clear_holds,
  input  logic                      hold_toggle,
  input  logic                      cursor_prev,
  input  logic                      cursor_next,
  output logic [NUM_DICE*DIE_W-1:0] dice_vals,
  output logic [NUM_DICE-1:0]       hold_mask,
  output logic [CURSOR_W-1:0]       cursor,
  output logic                      busy,
  output logic                      roll_done,
  output logic                      dice_valid
);

  localparam int unsigned TW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
  localparam int unsigned AW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
  localparam logic [CURSOR_W-1:0] LAST_DIE = CURSOR_W'(NUM_DICE - 1);

  roll_state_t                      state_q;
  logic [TW-1:0]                    tick_q;
  logic [AW-1:0]                    pass_q;
  logic [CURSOR_W-1:0]              idx_q;
  logic [NUM_DICE-1:0]              snap_q;
  logic [NUM_DICE-1:0][DIE_W-1:0]   dice_q;
  logic                             busy_q;
  logic                             done_q;

  logic [NUM_DICE-1:0]              hold_q,   hold_d;
  logic [CURSOR_W-1:0]              cursor_q, cursor_d;
  logic                             valid_q,  valid_d;

  logic [15:0]                      lfsr;
  logic                             unused_lfsr_hi;

  dice_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .lfsr  (lfsr)
  );

  // Only the low byte feeds the face map.
  assign unused_lfsr_hi = ^lfsr[15:8];

  // Hold mask, cursor and turn-valid flag; clear_holds beats everything when idle.
  always_comb begin
    hold_d   = hold_q;
    cursor_d = cursor_q;
    valid_d  = valid_q;
    if (!busy_q && clear_holds) begin
      hold_d   = '0;
      cursor_d = '0;
      valid_d  = 1'b0;
    end else begin
      // Toggle acts on the cursor position as it was before any move this cycle.
      if (hold_toggle && !busy_q && valid_q) begin
        hold_d[cursor_q] = ~hold_q[cursor_q];
      end
      if (cursor_next && !cursor_prev) begin
        cursor_d = (cursor_q == LAST_DIE) ? '0 : cursor_q + 3'd1;
      end else if (cursor_prev && !cursor_next) begin
        cursor_d = (cursor_q == '0) ? LAST_DIE : cursor_q - 3'd1;
      end
      if (state_q == ST_DONE) begin
        valid_d = 1'b1;
      end
    end
  end

  // Register the hold/cursor/valid state.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q   <= '0;
      cursor_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      cursor_q <= cursor_d;
      valid_q  <= valid_d;
    end
  end

  // Roll FSM with registered busy/roll_done and the dice register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      pass_q  <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_DICE; i++) begin
        dice_q[i] <= DIE_W'(FACE_MIN);
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (roll_req && !clear_holds) begin
            // Snapshot so hold edits during the roll cannot disturb it.
            snap_q <= hold_q;
            busy_q <= 1'b1;
            tick_q <= '0;
            pass_q <= '0;
            idx_q  <= '0;
            if (&hold_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SHUFFLE;
            end
          end
        end
        ST_SHUFFLE: begin
          if (tick_q == TW'(TICK_DIV - 1)) begin
            tick_q  <= '0;
            idx_q   <= '0;
            state_q <= ST_UPDATE;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        ST_UPDATE: begin
          // One die per clock, each sampling a fresh LFSR value.
          if (!snap_q[idx_q]) begin
            dice_q[idx_q] <= face_map(lfsr[7:0]);
          end
          if (idx_q == LAST_DIE) begin
            idx_q <= '0;
            if (pass_q == AW'(ANIM_TICKS - 1)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              pass_q  <= pass_q + AW'(1);
              state_q <= ST_SHUFFLE;
            end
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dice_vals  = dice_q;
  assign hold_mask  = hold_q;
  assign cursor     = cursor_q;
  assign busy       = busy_q;
  assign roll_done  = done_q;
  assign dice_valid = valid_q;

endmodule

// File: tb/tb_dice_roll_sequencer.sv
// Directed bench for dice_roll_sequencer with a cycle-level reference model.
// The model tracks each roll by its offset from the first busy cycle and writes faces from its own LFSR.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_dice_roll_sequencer;

  localparam int TD  = 4;
  localparam int AT  = 2;
  localparam int ND  = 5;
  localparam int ROLL_LEN = AT * (TD + ND) + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        roll_req = 1'b0;
  logic        clear_holds = 1'b0;
  logic        hold_toggle = 1'b0;
  logic        cursor_prev = 1'b0;
  logic        cursor_next = 1'b0;
  logic [14:0] dice_vals;
  logic [4:0]  hold_mask;
  logic [2:0]  cursor;
  logic        busy;
  logic        roll_done;
  logic        dice_valid;

  int n_tests = 0;
  int n_fail  = 0;

  dice_roll_sequencer #(
    .ANIM_TICKS (AT),
    .TICK_DIV   (TD),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .roll_req    (roll_req),
    .clear_holds (clear_holds),
    .hold_toggle (hold_toggle),
    .cursor_prev (cursor_prev),
    .cursor_next (cursor_next),
    .dice_vals   (dice_vals),
    .hold_mask   (hold_mask),
    .cursor      (cursor),
    .busy        (busy),
    .roll_done   (roll_done),
    .dice_valid  (dice_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_lfsr;
  logic [2:0]  m_dice [ND];
  logic [4:0]  m_hold;
  logic [4:0]  m_snap;
  int          m_cursor;
  bit          m_busy, m_done, m_valid, m_live;
  int          m_off, m_len;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [2:0] face(input logic [7:0] b);
    int p;
    p = int'(b) * 6;
    return 3'(p / 256 + 1);
  endfunction

  initial m_live = 1'b0;

  always @(posedge clk) begin
    logic [15:0] cur;
    bit was_busy, was_valid;
    int pos;
    if (reset) begin
      m_lfsr = 16'hACE1;
      for (int i = 0; i < ND; i++) m_dice[i] = 3'd1;
      m_hold = '0; m_snap = '0; m_cursor = 0;
      m_busy = 0; m_done = 0; m_valid = 0; m_off = 0; m_len = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      cur = m_lfsr;
      was_busy = m_busy;
      was_valid = m_valid;
      m_lfsr = lfsr_step(m_lfsr);
      if (was_busy) begin
        if (m_off == m_len - 1) begin
          m_busy = 0; m_done = 0; m_valid = 1;
        end else begin
          pos = m_off % (TD + ND);
          if (pos >= TD && !m_snap[pos - TD]) m_dice[pos - TD] = face(cur[7:0]);
          m_off++;
          m_done = (m_off == m_len - 1);
        end
      end else if (roll_req && !clear_holds) begin
        m_snap = m_hold;
        m_len  = (m_hold == 5'h1F) ? 1 : ROLL_LEN;
        m_off  = 0;
        m_busy = 1;
        m_done = (m_len == 1);
      end
      if (!was_busy && clear_holds) begin
        m_hold = '0; m_cursor = 0; m_valid = 0;
      end else begin
        if (hold_toggle && !was_busy && was_valid) m_hold[m_cursor] = ~m_hold[m_cursor];
        if (cursor_next && !cursor_prev) m_cursor = (m_cursor + 1) % ND;
        else if (cursor_prev && !cursor_next) m_cursor = (m_cursor + ND - 1) % ND;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [14:0] exp_dice;
    if (m_live) begin
      for (int i = 0; i < ND; i++) exp_dice[3*i +: 3] = m_dice[i];
      chk("mdl_dice",   32'(dice_vals),  32'(exp_dice));
      chk("mdl_hold",   32'(hold_mask),  32'(m_hold));
      chk("mdl_cursor", 32'(cursor),     32'(m_cursor));
      chk("mdl_busy",   32'(busy),       32'(m_busy));
      chk("mdl_done",   32'(roll_done),  32'(m_done));
      chk("mdl_valid",  32'(dice_valid), 32'(m_valid));
    end
  end

  // Waits (bounded) for roll_done; returns at the falling edge of the roll_done cycle.
  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (roll_done) begin
        seen = 1;
        break;
      end
      step();
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_done: roll_done not seen within %0d cycles", budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [2:0] keep0, keep2;

    // 1: reset values
    step(); step(); step();
    @(negedge clk);
    chk("rst_dice",   32'(dice_vals),  32'h1249);
    chk("rst_hold",   32'(hold_mask),  32'h0);
    chk("rst_cursor", 32'(cursor),     32'h0);
    chk("rst_busy",   32'(busy),       32'h0);
    chk("rst_valid",  32'(dice_valid), 32'h0);
    step();
    reset = 1'b0;

    // 2: first roll, cycle 0 carries roll_req
    roll_req = 1'b1;
    for (int c = 0; c <= 22; c++) begin
      @(negedge clk);
      chk("t2_busy",  32'(busy),       32'(c >= 1 && c <= 19));
      chk("t2_done",  32'(roll_done),  32'(c == 19));
      chk("t2_valid", 32'(dice_valid), 32'(c >= 20));
      if (c == 19) begin
        for (int k = 0; k < ND; k++)
          chk("t2_range", 32'(dice_vals[3*k +: 3] >= 3'd1 && dice_vals[3*k +: 3] <= 3'd6), 32'd1);
      end
      step();
      roll_req = 1'b0;
    end

    // 3: hold dice 0 and 2 (toggle together with a move hits the old position)
    hold_toggle = 1'b1; cursor_next = 1'b1; step(); hold_toggle = 1'b0; cursor_next = 1'b0;
    cursor_next = 1'b1; step(); cursor_next = 1'b0;
    hold_toggle = 1'b1; step(); hold_toggle = 1'b0;
    @(negedge clk);
    chk("t3_hold",   32'(hold_mask), 32'h05);
    chk("t3_cursor", 32'(cursor),    32'h2);
    keep0 = m_dice[0];
    keep2 = m_dice[2];
    step();
    roll_req = 1'b1; step(); roll_req = 1'b0;
    wait_done(40);
    chk("t3_die0_held", 32'(dice_vals[2:0]), 32'(keep0));
    chk("t3_die2_held", 32'(dice_vals[8:6]), 32'(keep2));
    step();

    // 4: hold everything, then roll
    cursor_prev = 1'b1; step(); cursor_prev = 1'b0;
    hold_toggle = 1'b1; step(); hold_toggle = 1'b0;
    cursor_next = 1'b1; step(); step(); cursor_next = 1'b0;
    hold_toggle = 1'b1; step(); hold_toggle = 1'b0;
    cursor_next = 1'b1; step(); cursor_next = 1'b0;
    hold_toggle = 1'b1; step(); hold_toggle = 1'b0;
    @(negedge clk);
    chk("t4_hold", 32'(hold_mask), 32'h1F);
    step();
    roll_req = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      chk("t4_busy", 32'(busy),      32'(c == 1));
      chk("t4_done", 32'(roll_done), 32'(c == 1));
      step();
      roll_req = 1'b0;
    end

    // 5: boundaries
    clear_holds = 1'b1; step(); clear_holds = 1'b0;
    @(negedge clk);
    chk("t5_clr_hold",   32'(hold_mask),  32'h0);
    chk("t5_clr_cursor", 32'(cursor),     32'h0);
    chk("t5_clr_valid",  32'(dice_valid), 32'h0);
    step();
    hold_toggle = 1'b1; step(); hold_toggle = 1'b0;
    @(negedge clk);
    chk("t5_toggle_invalid", 32'(hold_mask), 32'h0);
    step();
    cursor_prev = 1'b1; step(); cursor_prev = 1'b0;
    @(negedge clk);
    chk("t5_prev_wrap", 32'(cursor), 32'h4);
    step();
    cursor_next = 1'b1; step(); cursor_next = 1'b0;
    @(negedge clk);
    chk("t5_next_wrap", 32'(cursor), 32'h0);
    step();
    cursor_next = 1'b1; cursor_prev = 1'b1; step(); cursor_next = 1'b0; cursor_prev = 1'b0;
    @(negedge clk);
    chk("t5_both_nomove", 32'(cursor), 32'h0);
    step();
    clear_holds = 1'b1; roll_req = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      chk("t5_clr_roll_busy", 32'(busy), 32'h0);
      step();
      clear_holds = 1'b0; roll_req = 1'b0;
    end
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      roll_req = (c == 0 || c == 7);
      @(negedge clk);
      if (roll_done) cnt++;
      step();
    end
    roll_req = 1'b0;
    chk("t5_midroll_one_done", 32'(cnt), 32'd1);

    // 6: reset during UPDATE (cycles 5..9 of the roll)
    cursor_next = 1'b1; step(); cursor_next = 1'b0;
    hold_toggle = 1'b1; step(); hold_toggle = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      roll_req = (c == 0);
      reset    = (c == 6);
      @(negedge clk);
      if (roll_done) cnt++;
      if (c == 7) begin
        chk("t6_dice",   32'(dice_vals),  32'h1249);
        chk("t6_hold",   32'(hold_mask),  32'h0);
        chk("t6_cursor", 32'(cursor),     32'h0);
        chk("t6_busy",   32'(busy),       32'h0);
        chk("t6_valid",  32'(dice_valid), 32'h0);
      end
      step();
    end
    roll_req = 1'b0;
    reset = 1'b0;
    chk("t6_no_done", 32'(cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
